// File: rtl/polar_io_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : polar_io_pkg                                                 |
// | Description : Shared types, constants and helpers for the polar decoder    |
// |               stream front end (LLR input loader).                         |
// |               - loader_state_t : loader FSM state encoding                 |
// |               - calc_addr_width: BRAM word address width from N and lanes  |
// |               - sat_sym        : symmetric saturation to a signed width    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package polar_io_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2
  } loader_state_t;

  // Word address width: one BRAM word holds `lanes` LLRs of a 2^max_log_n frame.
  function automatic int unsigned calc_addr_width(input int unsigned max_log_n,
                                                  input int unsigned lanes);
    return max_log_n - $clog2(lanes);
  endfunction

  localparam int unsigned DEF_MAX_LOG_N  = 10;
  localparam int unsigned DEF_LANES      = 4;
  localparam int unsigned DEF_ADDR_WIDTH = calc_addr_width(DEF_MAX_LOG_N, DEF_LANES);

  // Clamp x into +/-(2^(out_w-1)-1). The range is symmetric on purpose: the
  // most-negative code of out_w bits is never produced, so the decoder can
  // negate any stored LLR without overflow.
  function automatic int sat_sym(input int x, input int out_w);
    int lim;
    lim = (1 << (out_w - 1)) - 1;
    if (x > lim) begin
      return lim;
    end else if (x < -lim) begin
      return -lim;
    end else begin
      return x;
    end
  endfunction

endpackage : polar_io_pkg
`default_nettype wire

// File: rtl/llr_saturate.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : llr_saturate                                                 |
// | Description : Combinational single-lane symmetric saturation of a signed   |
// |               channel LLR from IN_WIDTH to LLR_WIDTH bits.                 |
// | Ports       : llr_i  in  IN_WIDTH   signed incoming LLR                    |
// |               llr_o  out LLR_WIDTH  signed clamped LLR                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module llr_saturate
  import polar_io_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 8,
  parameter int unsigned LLR_WIDTH = 6
) (
  input  logic signed [IN_WIDTH-1:0]  llr_i,
  output logic signed [LLR_WIDTH-1:0] llr_o
);

  int w_sat;

  // Signed widening to int, clamp, then narrow; the clamped value always fits.
  assign w_sat = sat_sym(int'(llr_i), int'(LLR_WIDTH));
  assign llr_o = LLR_WIDTH'(w_sat);

endmodule : llr_saturate
`default_nettype wire

// File: rtl/llr_input_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : llr_input_loader                                             |
// | Description : Multi-lane AXI-Stream front end of the polar decoder. Loads  |
// |               one frame of channel LLRs per start, saturates each lane and |
// |               writes packed words into the LLR init BRAM. Detects early,   |
// |               missing tlast and bad code-length configuration.             |
// | Ports       : clk, reset (async, active-high)                              |
// |               start, log_n              frame request / code length exp.   |
// |               saxis_tvalid/tlast/tdata  stream input                       |
// |               saxis_tready              stream ready (state decoded)       |
// |               bram_en/we/addr/wdata     registered BRAM write port         |
// |               frame_done                end of every frame attempt         |
// |               err_early_last, err_missing_last, err_cfg   error pulses     |
// |               busy                      FSM not idle                       |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module llr_input_loader
  import polar_io_pkg::*;
#(
  parameter int unsigned MAX_LOG_N  = DEF_MAX_LOG_N,
  parameter int unsigned LANES      = DEF_LANES,
  parameter int unsigned IN_WIDTH   = 8,
  parameter int unsigned LLR_WIDTH  = 6,
  parameter int unsigned ADDR_WIDTH = calc_addr_width(MAX_LOG_N, LANES)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [3:0]                    log_n,
  input  logic                          saxis_tvalid,
  input  logic                          saxis_tlast,
  input  logic [LANES*IN_WIDTH-1:0]     saxis_tdata,
  output logic                          saxis_tready,
  output logic                          bram_en,
  output logic                          bram_we,
  output logic [ADDR_WIDTH-1:0]         bram_addr,
  output logic [LANES*LLR_WIDTH-1:0]    bram_wdata,
  output logic                          frame_done,
  output logic                          err_early_last,
  output logic                          err_missing_last,
  output logic                          err_cfg,
  output logic                          busy
);

  // One extra counter bit so a full 2^ADDR_WIDTH-beat frame never wraps.
  localparam int unsigned c_cnt_w     = ADDR_WIDTH + 1;
  localparam logic [3:0]  c_log_lanes = 4'($clog2(LANES));
  localparam logic [3:0]  c_max_log_n = 4'(MAX_LOG_N);

  loader_state_t state_q, state_d;

  logic [c_cnt_w-1:0]          cnt_q, cnt_d;
  logic [c_cnt_w-1:0]          beats_q, beats_d;
  logic                        bram_we_q, bram_we_d;
  logic [ADDR_WIDTH-1:0]       bram_addr_q, bram_addr_d;
  logic [LANES*LLR_WIDTH-1:0]  bram_wdata_q, bram_wdata_d;
  logic                        early_q, early_d;
  logic                        missing_q, missing_d;
  logic                        cfg_q, cfg_d;
  logic                        done_q, done_d;
  // Normal and early ends report frame_done one cycle after their final write.
  logic                        done_pend_q, done_pend_d;
  logic                        w_done_now;

  logic [LANES*LLR_WIDTH-1:0]  w_sat_data;
  logic                        w_cfg_ok;
  logic                        w_last_beat;

  // --------------------------------------------------------------------------
  // Per-lane saturation
  // --------------------------------------------------------------------------
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    llr_saturate #(
      .IN_WIDTH (IN_WIDTH),
      .LLR_WIDTH(LLR_WIDTH)
    ) u_sat (
      .llr_i(saxis_tdata[k*IN_WIDTH +: IN_WIDTH]),
      .llr_o(w_sat_data[k*LLR_WIDTH +: LLR_WIDTH])
    );
  end

  assign w_cfg_ok    = (log_n >= c_log_lanes) && (log_n <= c_max_log_n);
  assign w_last_beat = (cnt_q == (beats_q - c_cnt_w'(1)));

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state, counter and next values of the registered outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    beats_d      = beats_q;
    bram_we_d    = 1'b0;
    bram_addr_d  = bram_addr_q;
    bram_wdata_d = bram_wdata_q;
    early_d      = 1'b0;
    missing_d    = 1'b0;
    cfg_d        = 1'b0;
    done_pend_d  = 1'b0;
    w_done_now   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (w_cfg_ok) begin
            beats_d = c_cnt_w'(1) << (log_n - c_log_lanes);
            cnt_d   = '0;
            state_d = ST_LOAD;
          end else begin
            cfg_d      = 1'b1;
            w_done_now = 1'b1;
          end
        end
      end

      ST_LOAD: begin
        if (saxis_tvalid) begin
          bram_we_d    = 1'b1;
          bram_addr_d  = cnt_q[ADDR_WIDTH-1:0];
          bram_wdata_d = w_sat_data;
          cnt_d        = cnt_q + c_cnt_w'(1);
          if (w_last_beat) begin
            if (saxis_tlast) begin
              done_pend_d = 1'b1;
              state_d     = ST_IDLE;
            end else begin
              missing_d = 1'b1;
              state_d   = ST_FLUSH;
            end
          end else if (saxis_tlast) begin
            early_d     = 1'b1;
            done_pend_d = 1'b1;
            state_d     = ST_IDLE;
          end
        end
      end

      ST_FLUSH: begin
        if (saxis_tvalid && saxis_tlast) begin
          w_done_now = 1'b1;
          state_d    = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A config error in the cycle after a normal end merges into one pulse.
    done_d = w_done_now | done_pend_q;
  end

  // --------------------------------------------------------------------------
  // Counter and output registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      beats_q      <= '0;
      bram_we_q    <= 1'b0;
      bram_addr_q  <= '0;
      bram_wdata_q <= '0;
      early_q      <= 1'b0;
      missing_q    <= 1'b0;
      cfg_q        <= 1'b0;
      done_q       <= 1'b0;
      done_pend_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      beats_q      <= beats_d;
      bram_we_q    <= bram_we_d;
      bram_addr_q  <= bram_addr_d;
      bram_wdata_q <= bram_wdata_d;
      early_q      <= early_d;
      missing_q    <= missing_d;
      cfg_q        <= cfg_d;
      done_q       <= done_d;
      done_pend_q  <= done_pend_d;
    end
  end

  assign saxis_tready     = (state_q != ST_IDLE);
  assign busy             = (state_q != ST_IDLE);
  assign bram_en          = bram_we_q;
  assign bram_we          = bram_we_q;
  assign bram_addr        = bram_addr_q;
  assign bram_wdata       = bram_wdata_q;
  assign frame_done       = done_q;
  assign err_early_last   = early_q;
  assign err_missing_last = missing_q;
  assign err_cfg          = cfg_q;

endmodule : llr_input_loader
`default_nettype wire

// File: doc/llr_input_loader.md
# llr_input_loader

Multi-lane AXI-Stream front end of the polar decoder: accepts one frame of channel LLRs per `start`, saturates each lane to the decoder LLR width, and writes packed words into the LLR init BRAM. Code length is selectable per frame (N = 2^log_n), and framing errors are detected and recovered. It owns its own FSM and sits between the stream input and the LLR init BRAM. The top-level controller handshakes with it through `start` and `frame_done`.

## Interface
- `MAX_LOG_N`, 10: log2 of the largest supported code length.
- `LANES`, 4: LLRs per stream beat and per BRAM word; power of two, ≤ 2^MAX_LOG_N.
- `IN_WIDTH`, 8: signed width of each incoming LLR.
- `LLR_WIDTH`, 6: signed width of each stored LLR; ≤ IN_WIDTH.
- `ADDR_WIDTH`, MAX_LOG_N − log2(LANES): BRAM word address width.
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  one-cycle frame request; sampled only in IDLE.
- `log_n`  in  4  code length exponent; latched on accepted `start`.
- `saxis_tvalid`  in  1  stream valid.
- `saxis_tlast`  in  1  last beat of frame.
- `saxis_tdata`  in  LANES·IN_WIDTH  lane k at bits [k·IN_WIDTH +: IN_WIDTH]; lane 0 is the lowest LLR index.
- `saxis_tready`  out  1  stream ready.
- `bram_en`, `bram_we`  out  1  BRAM enable and write enable.
- `bram_addr`  out  ADDR_WIDTH  word address.
- `bram_wdata`  out  LANES·LLR_WIDTH  saturated lanes, same lane order as the input.
- `frame_done`  out  1  one-cycle pulse at the end of every frame attempt.
- `err_early_last`, `err_missing_last`, `err_cfg`  out  1  one-cycle pulses.
- `busy`  out  1  FSM not in IDLE.

## Operation
- FSM states: IDLE, LOAD, FLUSH.
- IDLE:
  - `start` with log2(LANES) ≤ `log_n` ≤ MAX_LOG_N: latch `beats` = 2^log_n / LANES, clear the beat counter, go to LOAD.
  - `start` with an out-of-range `log_n`: pulse `err_cfg` and `frame_done`, stay in IDLE.
- LOAD:
  - `saxis_tready` = 1.
  - Each handshake writes the saturated beat at address = beat counter, then increments the counter.
  - Handshake on beat `beats`−1 with tlast: normal end, go to IDLE.
  - Handshake on beat `beats`−1 without tlast: the write still happens; pulse `err_missing_last`, go to FLUSH.
  - Handshake with tlast before beat `beats`−1: the write still happens; pulse `err_early_last` and `frame_done`, go to IDLE.
- FLUSH:
  - `saxis_tready` = 1; beats are discarded with no BRAM writes.
  - On a handshake with tlast: pulse `frame_done`, go to IDLE.
- Saturation, per lane:
  - Clamp to the symmetric range ±(2^(LLR_WIDTH−1)−1).
  - The most-negative input also clamps to −(2^(LLR_WIDTH−1)−1). This applies even when IN_WIDTH = LLR_WIDTH, so −128 becomes −127.
- The counter is ADDR_WIDTH+1 bits wide and never wraps within a frame. Address 0 is restarted only by an accepted `start`.
- `saxis_tready` is low in IDLE. Any `start` outside IDLE is ignored.
- Reset (asynchronous, at any time, including mid-frame):
  - FSM goes to IDLE; all outputs go to 0, including `bram_we`; the counter is cleared.
  - A partially written frame is abandoned. No `frame_done` is produced for it.

## Timing
- `saxis_tready` and `busy` are decoded from the registered state; there is no combinational path from `saxis_tvalid`.
- BRAM port signals are registered:
  - A handshake in cycle t gives `bram_en` = `bram_we` = 1 in cycle t+1, with that beat's address and data.
  - `bram_en` is 0 whenever `bram_we` is 0.
- Normal end, final handshake in cycle t: the FSM is in IDLE at t+1 (tready low), the last write is at t+1, and `frame_done` pulses at t+2.
- Early-last handshake in cycle t: `err_early_last` pulses at t+1 together with its write, and `frame_done` pulses at t+2.
- Missing-last, final handshake in cycle t: `err_missing_last` pulses at t+1.
- FLUSH end, tlast handshake in cycle t: `frame_done` pulses at t+1.
- Config error, `start` in cycle t: `err_cfg` and `frame_done` both pulse at t+1.
- Back-to-back frames:
  - A `start` in the cycle after the final handshake (t+1) is accepted, and LOAD begins at t+2.
  - Minimum frame gap: 1 cycle of tready low.
- `saxis_tvalid` low in LOAD: counter holds, no write, no timeout.

## Structure
- Package `polar_io_pkg` holds:
  - the FSM state enum;
  - the `clog2`-derived address width constant;
  - the symmetric-saturation function, parametrised by input and output width.
- Sub-module `llr_saturate` is purely combinational, one lane, and is instantiated LANES times by generate.
- The FSM, counter and output registers live in the top module.

## Test plan
- LANES=4, log_n=5, 8 beats with tlast on beat 7 → addresses 0..7 written in order, `frame_done` 2 cycles after the last handshake, no error pulses.
- A lane value of 8'h80 with LLR_WIDTH=6 → stored −31. Values 8'h7F → +31, 8'h05 → 5, 8'hFB → −5.
- log_n=5, tlast on beat 3 → 4 writes (addresses 0..3), `err_early_last` pulse, `frame_done`, back in IDLE.
- log_n=5, no tlast on beat 7, then 3 extra beats with tlast on the third → 8 writes, `err_missing_last`, 3 beats discarded with no writes, then `frame_done`.
- Random tvalid gaps, then `start` in the cycle after the final handshake → second frame starts at address 0 with one idle cycle. Also `start` with log_n=1 → `err_cfg`, tready stays low.
- `reset` asserted after beat 4 of 8 → all outputs 0 immediately, IDLE. A new frame after release writes from address 0.
